// File: rtl/mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_unit_pkg: shared size codes, FSM encodings and IO window base. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_IO_BASE = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_IO_ACC = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    res = (size == 2'b11) ? SZ_WORD : size;
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic res;
    case (size)
      SZ_HALF: res = low[0];
      SZ_WORD: res = |low;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
// ----------------------------------------------------------------------------
// mem_access_unit_load_extend: lane shift plus sign/zero extension of a read word. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit: MEM-stage load/store engine for data RAM and the IO window. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] IO_BASE     = DEF_IO_BASE,
  parameter int unsigned IO_TIMEOUT  = 15,
  parameter int unsigned DADDR_W     = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall_out,
  output logic [31:0]        rdata_out,
  output logic               is_io_out,
  output logic               addr_exc_out,
  output logic               dmem_en,
  output logic [3:0]         dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic               io_rd,
  output logic               io_wr,
  output logic [9:0]         io_addr,
  output logic [31:0]        io_wdata,
  input  logic [31:0]        io_rdata,
  input  logic               io_ready
);

  localparam int unsigned CNT_MAX = (MEM_LATENCY > IO_TIMEOUT) ? MEM_LATENCY : IO_TIMEOUT;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [9:0]         lat_addr;
  logic [31:0]        lat_wdata;
  logic [1:0]         lat_size;
  logic               lat_unsigned;
  logic               lat_write;
  logic [31:0]        rdata_q;
  logic               is_io_q;

  logic [1:0]  size_n;
  logic        accept, misal, exc, ok, to_io;
  logic        ram_rd, ram_wr, io_start;
  logic        mem_last, io_done;
  logic [31:0] ext_word, ext_data;
  logic [1:0]  ext_off;

  always_comb begin
    size_n   = norm_size(req_size);
    to_io    = (req_addr >= IO_BASE);
    misal    = is_misaligned(size_n, req_addr[1:0]);
    accept   = (state == ST_IDLE) && (req_read || req_write) && !reset;
    exc      = accept && misal;
    ok       = accept && !misal;
    ram_rd   = ok && !to_io && req_read;
    ram_wr   = ok && !to_io && !req_read;
    io_start = ok && to_io;
    mem_last = (cnt == CNT_W'(MEM_LATENCY));
    io_done  = io_ready || (cnt == CNT_W'(IO_TIMEOUT));
  end

  // IO data is right-aligned on its bus, so only RAM words need a lane shift.
  always_comb begin
    ext_word = (state == ST_IO_ACC) ? io_rdata : dmem_rdata;
    ext_off  = (state == ST_IO_ACC) ? 2'b00 : lat_addr[1:0];
  end

  mem_access_unit_load_extend u_load_extend (
    .word        (ext_word),
    .offset      (ext_off),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (ext_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ram_rd)        next_state = ST_MEM_RD;
        else if (io_start) next_state = ST_IO_ACC;
      end
      ST_MEM_RD: if (mem_last) next_state = ST_DONE;
      ST_IO_ACC: if (io_done)  next_state = ST_DONE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_write    <= 1'b0;
      rdata_q      <= '0;
      is_io_q      <= 1'b0;
    end else begin
      if (ram_rd || io_start) begin
        cnt          <= CNT_W'(1);
        lat_addr     <= req_addr[9:0];
        lat_wdata    <= req_wdata;
        lat_size     <= size_n;
        lat_unsigned <= req_unsigned;
        lat_write    <= !req_read;
      end else if (((state == ST_MEM_RD) || (state == ST_IO_ACC)) && (cnt != CNT_W'(CNT_MAX))) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == ST_MEM_RD) && mem_last) begin
        rdata_q <= ext_data;
        is_io_q <= 1'b0;
      end
      // A read that times out returns zero instead of whatever sits on the bus.
      if ((state == ST_IO_ACC) && io_done) begin
        is_io_q <= 1'b1;
        if (!lat_write) rdata_q <= io_ready ? ext_data : 32'h0;
      end
    end
  end

  always_comb begin
    stall_out    = 1'b0;
    addr_exc_out = 1'b0;
    dmem_en      = 1'b0;
    dmem_we      = 4'b0000;
    dmem_addr    = '0;
    dmem_wdata   = 32'h0;
    io_rd        = 1'b0;
    io_wr        = 1'b0;
    io_addr      = 10'h0;
    io_wdata     = 32'h0;
    if (!reset) begin
      addr_exc_out = exc;
      stall_out    = ram_rd || io_start || (state == ST_MEM_RD) || (state == ST_IO_ACC);
      if (ram_rd || ram_wr) begin
        dmem_en   = 1'b1;
        dmem_addr = req_addr[DADDR_W+1:2];
      end
      if (ram_wr) begin
        case (size_n)
          SZ_BYTE: begin
            dmem_we    = 4'b0001 << req_addr[1:0];
            dmem_wdata = {4{req_wdata[7:0]}};
          end
          SZ_HALF: begin
            dmem_we    = req_addr[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{req_wdata[15:0]}};
          end
          default: begin
            dmem_we    = 4'b1111;
            dmem_wdata = req_wdata;
          end
        endcase
      end
      if (state == ST_IO_ACC) begin
        io_rd    = !lat_write;
        io_wr    = lat_write;
        io_addr  = lat_addr;
        io_wdata = lat_wdata;
      end
    end
  end

  assign rdata_out = rdata_q;
  assign is_io_out = is_io_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit: directed self-checking bench for mem_access_unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall_out, is_io_out, addr_exc_out;
  logic [31:0] rdata_out;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        io_rd, io_wr;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ready;

  int checks   = 0;
  int failures = 0;

  // RAM model: the read word appears exactly two cycles after the enable cycle.
  logic [31:0] ram_word = 32'h0;
  logic        rd_pipe0 = 1'b0;
  logic        rd_pipe1 = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rd_pipe0 <= dmem_en && (dmem_we == 4'b0000);
    rd_pipe1 <= rd_pipe0;
  end
  assign dmem_rdata = rd_pipe1 ? ram_word : 32'hDEAD_BEEF;

  mem_access_unit dut (
    .clock        (clock),
    .reset        (reset),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall_out    (stall_out),
    .rdata_out    (rdata_out),
    .is_io_out    (is_io_out),
    .addr_exc_out (addr_exc_out),
    .dmem_en      (dmem_en),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_addr      (io_addr),
    .io_wdata     (io_wdata),
    .io_rdata     (io_rdata),
    .io_ready     (io_ready)
  );

  task automatic idle_inputs();
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    io_ready     = 1'b0;
    io_rdata     = 32'h0;
  endtask

  // Holds a request until the stall drops, recording the accept-cycle bus values.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           output int stalls, output logic f_en, output logic [3:0] f_we,
                           output logic [31:0] f_wd, output logic f_exc,
                           output logic [13:0] f_addr);
    stalls = 0;
    @(negedge clock);
    req_read = rd; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    f_en = dmem_en; f_we = dmem_we; f_wd = dmem_wdata; f_exc = addr_exc_out; f_addr = dmem_addr;
    while (stall_out === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    if (stalls >= 40) begin
      checks++; failures++;
      $display("FAIL access_timeout: stall still high after %0d cycles, required release", stalls);
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0100;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", stall_out); end
    checks++; if (dmem_en !== 1'b0) begin failures++; $display("FAIL reset_dmem_en: got %b required 0", dmem_en); end
    checks++; if (rdata_out !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h required 0", rdata_out); end
    checks++; if (is_io_out !== 1'b0 || io_rd !== 1'b0 || io_wr !== 1'b0) begin failures++; $display("FAIL reset_io: got is_io=%b rd=%b wr=%b required 0", is_io_out, io_rd, io_wr); end
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ram_loads();
    int st; logic en, exc; logic [3:0] we; logic [31:0] wd; logic [13:0] da;
    ram_word = 32'h80AB_CDEF;
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, st, en, we, wd, exc, da);
    checks++; if (st !== 3) begin failures++; $display("FAIL lbu_stall_cycles: got %0d required 3", st); end
    checks++; if (en !== 1'b1 || we !== 4'b0000 || da !== 14'h040) begin failures++; $display("FAIL lbu_bus: got en=%b we=%b addr=%h required 1 0000 040", en, we, da); end
    checks++; if (rdata_out !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata: got %h required 00000080", rdata_out); end
    checks++; if (is_io_out !== 1'b0) begin failures++; $display("FAIL lbu_is_io: got %b required 0", is_io_out); end
    ram_word = 32'h8001_1234;
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, st, en, we, wd, exc, da);
    checks++; if (rdata_out !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_rdata: got %h required ffff8001", rdata_out); end
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, st, en, we, wd, exc, da);
    checks++; if (rdata_out !== 32'h0000_1234) begin failures++; $display("FAIL lhu_rdata: got %h required 00001234", rdata_out); end
    ram_word = 32'h00F0_0000;
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, st, en, we, wd, exc, da);
    checks++; if (rdata_out !== 32'hFFFF_FFF0) begin failures++; $display("FAIL lb_rdata: got %h required fffffff0", rdata_out); end
    ram_word = 32'hCAFE_BABE;
    do_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0104, 32'h1111_1111, st, en, we, wd, exc, da);
    checks++; if (we !== 4'b0000 || st !== 3) begin failures++; $display("FAIL rw_read_wins: got we=%b stalls=%0d required 0000 3", we, st); end
    checks++; if (rdata_out !== 32'hCAFE_BABE) begin failures++; $display("FAIL lw_size3_rdata: got %h required cafebabe", rdata_out); end
  endtask

  task automatic test_ram_stores();
    int st; logic en, exc; logic [3:0] we; logic [31:0] wd; logic [13:0] da;
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_005A, st, en, we, wd, exc, da);
    checks++; if (we !== 4'b0010 || wd !== 32'h5A5A_5A5A) begin failures++; $display("FAIL sb_bus: got we=%b wdata=%h required 0010 5a5a5a5a", we, wd); end
    checks++; if (st !== 0 || en !== 1'b1) begin failures++; $display("FAIL sb_stall: got stalls=%0d en=%b required 0 1", st, en); end
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h1234_ABCD, st, en, we, wd, exc, da);
    checks++; if (we !== 4'b1100 || wd !== 32'hABCD_ABCD || da !== 14'h041) begin failures++; $display("FAIL sh_bus: got we=%b wdata=%h addr=%h required 1100 abcdabcd 041", we, wd, da); end
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0108, 32'h1234_ABCD, st, en, we, wd, exc, da);
    checks++; if (we !== 4'b1111 || wd !== 32'h1234_ABCD) begin failures++; $display("FAIL sw_bus: got we=%b wdata=%h required 1111 1234abcd", we, wd); end
  endtask

  task automatic test_misaligned();
    int st; logic en, exc; logic [3:0] we; logic [31:0] wd; logic [13:0] da;
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0, st, en, we, wd, exc, da);
    checks++; if (exc !== 1'b1 || en !== 1'b0 || st !== 0) begin failures++; $display("FAIL sw_misaligned: got exc=%b en=%b stalls=%0d required 1 0 0", exc, en, st); end
    checks++; if (addr_exc_out !== 1'b0 || io_wr !== 1'b0) begin failures++; $display("FAIL exc_pulse_end: got exc=%b io_wr=%b required 0 0", addr_exc_out, io_wr); end
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFF_FC11, 32'h0, st, en, we, wd, exc, da);
    checks++; if (exc !== 1'b1 || st !== 0) begin failures++; $display("FAIL lh_io_misaligned: got exc=%b stalls=%0d required 1 0", exc, st); end
  endtask

  task automatic test_io_read();
    int rd_cycles = 0; int k = 0;
    @(negedge clock);
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'hFFFF_FC10; io_rdata = 32'h0000_1234;
    #1;
    checks++; if (stall_out !== 1'b1 || dmem_en !== 1'b0) begin failures++; $display("FAIL io_accept: got stall=%b en=%b required 1 0", stall_out, dmem_en); end
    while (stall_out === 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
      io_ready = (k == 3);
      #1;
      if (io_rd === 1'b1) rd_cycles++;
      if (k == 1) begin
        checks++; if (io_addr !== 10'h010) begin failures++; $display("FAIL io_addr: got %h required 010", io_addr); end
      end
    end
    checks++; if (rd_cycles !== 3) begin failures++; $display("FAIL io_rd_cycles: got %0d required 3", rd_cycles); end
    checks++; if (rdata_out !== 32'h0000_1234 || is_io_out !== 1'b1) begin failures++; $display("FAIL io_rdata: got %h is_io=%b required 00001234 1", rdata_out, is_io_out); end
    idle_inputs();
  endtask

  task automatic test_io_timeout();
    int rd_cycles = 0; int k = 0;
    @(negedge clock);
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'hFFFF_FC20; io_rdata = 32'hFFFF_FFFF;
    #1;
    while (stall_out === 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
      #1;
      if (io_rd === 1'b1) rd_cycles++;
    end
    checks++; if (rd_cycles !== 15) begin failures++; $display("FAIL io_timeout_cycles: got %0d required 15", rd_cycles); end
    checks++; if (rdata_out !== 32'h0 || is_io_out !== 1'b1) begin failures++; $display("FAIL io_timeout_rdata: got %h is_io=%b required 0 1", rdata_out, is_io_out); end
    idle_inputs();
  endtask

  task automatic test_io_write();
    int wr_cycles = 0; int k = 0; logic [31:0] seen_wd = 32'h0;
    @(negedge clock);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'hFFFF_FC24; req_wdata = 32'h1122_3344;
    #1;
    checks++; if (stall_out !== 1'b1 || dmem_en !== 1'b0 || io_wr !== 1'b0) begin failures++; $display("FAIL iow_accept: got stall=%b en=%b io_wr=%b required 1 0 0", stall_out, dmem_en, io_wr); end
    while (stall_out === 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
      io_ready = (k == 1);
      #1;
      if (io_wr === 1'b1) begin wr_cycles++; seen_wd = io_wdata; end
    end
    checks++; if (wr_cycles !== 1 || seen_wd !== 32'h1122_3344) begin failures++; $display("FAIL iow_strobe: got cycles=%0d wdata=%h required 1 11223344", wr_cycles, seen_wd); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int k = 0;
    ram_word = 32'h0102_0304;
    @(negedge clock);
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0120;
    #1;
    while (stall_out === 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
      #1;
    end
    req_read = 1'b0; req_write = 1'b1; req_addr = 32'h0000_0124; req_wdata = 32'h5555_AAAA;
    #1;
    checks++; if (dmem_en !== 1'b0 || rdata_out !== 32'h0102_0304) begin failures++; $display("FAIL done_holdoff: got en=%b rdata=%h required 0 01020304", dmem_en, rdata_out); end
    @(negedge clock);
    #1;
    checks++; if (dmem_en !== 1'b1 || dmem_we !== 4'b1111 || stall_out !== 1'b0) begin failures++; $display("FAIL next_store: got en=%b we=%b stall=%b required 1 1111 0", dmem_en, dmem_we, stall_out); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_load();
    ram_word = 32'h7777_7777;
    @(negedge clock);
    req_read = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0130;
    @(negedge clock);
    #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL mid_load_stall: got %b required 1", stall_out); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_mid_load: got stall=%b required 0", stall_out); end
    @(negedge clock);
    #1;
    checks++; if (stall_out !== 1'b0 || rdata_out !== 32'h0) begin failures++; $display("FAIL after_reset_idle: got stall=%b rdata=%h required 0 0", stall_out, rdata_out); end
  endtask

  initial begin
    test_reset();
    test_ram_loads();
    test_ram_stores();
    test_misaligned();
    test_io_read();
    test_io_timeout();
    test_io_write();
    test_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
